// File: rtl/stage_seq_pkg.sv
// Shared types and constants for the stage sequencer: state encoding and phase-index sizing.
// Phase counts are clamped to MAX_PHASES when turned into a last-phase index.
package stage_seq_pkg;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  localparam int MAX_PHASES = 8;
  localparam int PH_W       = 3;

  function automatic logic [PH_W-1:0] phase_limit(input int phases);
    int n;
    n = (phases > MAX_PHASES) ? MAX_PHASES : phases;
    return PH_W'(n - 1);
  endfunction

endpackage

// File: rtl/stage_phase_cnt.sv
// Loadable phase counter shared by fetch and execute; last flags phase == limit.
// Updates on the falling edge, one step per non-stalled period; load wins over advance.
module stage_phase_cnt
  import stage_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            adv,
  input  logic [PH_W-1:0] limit,
  output logic [PH_W-1:0] phase,
  output logic            last
);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (load) begin
      phase <= '0;
    end else if (adv) begin
      phase <= phase + 1'b1;
    end
  end

  assign last = (phase == limit);

endmodule

// File: rtl/stage_seq.sv
// Stage sequencer: WAIT -> FETCH(0..F-1) -> EXEC(0..E-1) -> repeat/halt, one phase per period, stall freezes.
// Falling-edge state; outputs are registers or state decodes. STAGE_SEQ_STEP_EN adds step_mode.
module stage_seq
  import stage_seq_pkg::*;
#(
  parameter int FETCH_PHASES = 2,
  parameter int EXEC_PHASES  = 2,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    halt,
  input  logic                    stall,
`ifdef STAGE_SEQ_STEP_EN
  input  logic                    step_mode,
`endif
  output logic                    waits,
  output logic [FETCH_PHASES-1:0] fetch,
  output logic [EXEC_PHASES-1:0]  exec,
  output logic                    busy,
  output logic                    retire,
  output logic [CNT_W-1:0]        retired_cnt
);

  localparam logic [PH_W-1:0] FETCH_LIM = phase_limit(FETCH_PHASES);
  localparam logic [PH_W-1:0] EXEC_LIM  = phase_limit(EXEC_PHASES);

  state_t          state, state_nxt;
  logic            halt_pend;
  logic            retire_nxt;
  logic            ph_load, ph_adv, ph_last;
  logic [PH_W-1:0] ph_limit, phase;
  logic            step;

`ifdef STAGE_SEQ_STEP_EN
  assign step = step_mode;
`else
  assign step = 1'b0;
`endif

  assign ph_limit = (state == ST_EXEC) ? EXEC_LIM : FETCH_LIM;

  stage_phase_cnt u_phase (
    .clk   (clk),
    .rst   (rst),
    .load  (ph_load),
    .adv   (ph_adv),
    .limit (ph_limit),
    .phase (phase),
    .last  (ph_last)
  );

  // The counter is held at zero in WAIT so FETCH(0) starts cleanly.
  always_comb begin
    state_nxt  = state;
    retire_nxt = 1'b0;
    ph_load    = 1'b0;
    ph_adv     = 1'b0;
    case (state)
      ST_WAIT: begin
        ph_load = 1'b1;
        if (run) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (!stall) begin
          if (ph_last) begin
            state_nxt = ST_EXEC;
            ph_load   = 1'b1;
          end else begin
            ph_adv = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          if (ph_last) begin
            retire_nxt = 1'b1;
            ph_load    = 1'b1;
            state_nxt  = (halt_pend || halt || step) ? ST_WAIT : ST_FETCH;
          end else begin
            ph_adv = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_WAIT;
        ph_load   = 1'b1;
      end
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_WAIT;
      halt_pend   <= 1'b0;
      retire      <= 1'b0;
      retired_cnt <= '0;
    end else begin
      state  <= state_nxt;
      retire <= retire_nxt;
      if (retire_nxt) retired_cnt <= retired_cnt + 1'b1;
      // Clearing on WAIT entry wins over a halt seen on that same edge.
      if (state != ST_WAIT) begin
        if (state_nxt == ST_WAIT) halt_pend <= 1'b0;
        else if (halt)            halt_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    fetch = '0;
    exec  = '0;
    for (int i = 0; i < FETCH_PHASES; i++)
      fetch[i] = (state == ST_FETCH) && (phase == PH_W'(i));
    for (int i = 0; i < EXEC_PHASES; i++)
      exec[i] = (state == ST_EXEC) && (phase == PH_W'(i));
  end

  assign waits = (state == ST_WAIT);
  assign busy  = ~waits;

endmodule

// File: tb/tb_stage_seq.sv
// Bench for stage_seq: two instances (2/2/16 and 3/1/2) share stimulus and are checked
// each period against an instruction-progress model, plus directed literal expectations.
module tb_stage_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0, halt = 1'b0, stall = 1'b0, step_mode = 1'b0;

  logic        a_waits, a_busy, a_retire;
  logic [1:0]  a_fetch, a_exec;
  logic [15:0] a_cnt;
  logic        b_waits, b_busy, b_retire;
  logic [2:0]  b_fetch;
  logic [0:0]  b_exec;
  logic [1:0]  b_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: pos = -1 in WAIT, else progress 0..F+E-1 through the instruction.
  int a_pos = -1, b_pos = -1;
  bit a_hp = 0, b_hp = 0, a_ret = 0, b_ret = 0;
  int a_mcnt = 0, b_mcnt = 0;

  always #5 clk = ~clk;

  stage_seq u_a (
    .clk(clk), .rst(rst), .run(run), .halt(halt), .stall(stall),
`ifdef STAGE_SEQ_STEP_EN
    .step_mode(step_mode),
`endif
    .waits(a_waits), .fetch(a_fetch), .exec(a_exec), .busy(a_busy),
    .retire(a_retire), .retired_cnt(a_cnt)
  );

  stage_seq #(.FETCH_PHASES(3), .EXEC_PHASES(1), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .run(run), .halt(halt), .stall(stall),
`ifdef STAGE_SEQ_STEP_EN
    .step_mode(step_mode),
`endif
    .waits(b_waits), .fetch(b_fetch), .exec(b_exec), .busy(b_busy),
    .retire(b_retire), .retired_cnt(b_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int f, input int e, input int w,
                            inout int pos, inout bit hp, inout int cnt, output bit ret);
    ret = 1'b0;
    if (rst) begin
      pos = -1; hp = 1'b0; cnt = 0;
    end else if (pos < 0) begin
      if (run) pos = 0;
    end else begin
      if (halt) hp = 1'b1;
      if (!stall) begin
        if (pos == f + e - 1) begin
          ret = 1'b1;
          cnt = (cnt + 1) % (1 << w);
          if (hp || step_mode) begin pos = -1; hp = 1'b0; end
          else pos = 0;
        end else begin
          pos++;
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_fetch(input int pos, input int f);
    return (pos >= 0 && pos < f) ? (32'd1 << pos) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_exec(input int pos, input int f);
    return (pos >= f) ? (32'd1 << (pos - f)) : 32'd0;
  endfunction

  task automatic compare_all();
    chk("a_waits",  32'(a_waits),  32'(a_pos < 0));
    chk("a_busy",   32'(a_busy),   32'(a_pos >= 0));
    chk("a_fetch",  32'(a_fetch),  exp_fetch(a_pos, 2));
    chk("a_exec",   32'(a_exec),   exp_exec(a_pos, 2));
    chk("a_retire", 32'(a_retire), 32'(a_ret));
    chk("a_cnt",    32'(a_cnt),    32'(a_mcnt));
    chk("b_waits",  32'(b_waits),  32'(b_pos < 0));
    chk("b_busy",   32'(b_busy),   32'(b_pos >= 0));
    chk("b_fetch",  32'(b_fetch),  exp_fetch(b_pos, 3));
    chk("b_exec",   32'(b_exec),   exp_exec(b_pos, 3));
    chk("b_retire", 32'(b_retire), 32'(b_ret));
    chk("b_cnt",    32'(b_cnt),    32'(b_mcnt));
  endtask

  task automatic models();
    model_step(2, 2, 16, a_pos, a_hp, a_mcnt, a_ret);
    model_step(3, 1, 2,  b_pos, b_hp, b_mcnt, b_ret);
  endtask

  task automatic drive(input bit r, input bit h, input bit s);
    run = r; halt = h; stall = s;
    models();
    @(posedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    models();
    @(posedge clk);
    compare_all();
    rst = 1'b0;
  endtask

  int wrap_exp[5] = '{1, 2, 3, 0, 1};

  initial begin
    // Reset state
    do_reset();
    chk("rst_waits", 32'(a_waits), 1);
    chk("rst_fetch", 32'(a_fetch), 0);
    chk("rst_exec", 32'(a_exec), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_retire", 32'(a_retire), 0);
    chk("rst_cnt", 32'(a_cnt), 0);

    // Free run: W,F0,F1,E0,E1,F0...
    drive(1, 0, 0);
    chk("run_f0", 32'(a_fetch), 32'b01);
    repeat (3) drive(0, 0, 0);
    chk("run_e1", 32'(a_exec), 32'b10);
    drive(0, 0, 0);
    chk("run_retire", 32'(a_retire), 1);
    chk("run_back_to_back", 32'(a_fetch), 32'b01);
    repeat (8) drive(0, 0, 0);
    chk("run_cnt12", 32'(a_cnt), 3);
    chk("run_cnt12_b", 32'(b_cnt), 3);
    chk("model_cnt12", 32'(a_mcnt), 3);

    // Halt pulse during F1 on the 3/1 instance completes the instruction
    do_reset();
    drive(1, 0, 0);
    drive(0, 0, 0);
    drive(0, 1, 0);
    chk("halt_b_f2", 32'(b_fetch), 32'b100);
    drive(0, 0, 0);
    chk("halt_b_e0", 32'(b_exec), 32'b1);
    drive(0, 0, 0);
    chk("halt_b_wait", 32'(b_waits), 1);
    chk("halt_b_cnt", 32'(b_cnt), 1);
    chk("halt_a_wait", 32'(a_waits), 1);

    // Stall E0 for 3 periods
    drive(1, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    repeat (3) drive(0, 0, 1);
    chk("stall_e0_held", 32'(a_exec), 32'b01);
    chk("stall_no_retire", 32'(a_retire), 0);
    drive(0, 0, 0);
    chk("stall_e1", 32'(a_exec), 32'b10);
    drive(0, 0, 0);
    chk("stall_retire", 32'(a_retire), 1);

    // Halt while stalled in F0 is latched
    drive(0, 1, 1);
    chk("hstall_f0", 32'(a_fetch), 32'b01);
    repeat (3) drive(0, 0, 0);
    chk("hstall_busy", 32'(a_busy), 1);
    drive(0, 0, 0);
    chk("hstall_wait", 32'(a_waits), 1);
    chk("hstall_retire", 32'(a_retire), 1);

    // 2-bit counter wrap
    do_reset();
    drive(1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      repeat (4) drive(0, 0, 0);
      chk("wrap_cnt", 32'(b_cnt), 32'(wrap_exp[k]));
    end

    // Asynchronous reset mid-E0
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("arst_pre_e0", 32'(a_exec), 32'b01);
    rst = 1'b1;
    #1;
    chk("arst_wait", 32'(a_waits), 1);
    chk("arst_exec", 32'(a_exec), 0);
    chk("arst_cnt", 32'(a_cnt), 0);
    models();
    @(posedge clk);
    compare_all();
    rst = 1'b0;

`ifdef STAGE_SEQ_STEP_EN
    step_mode = 1'b1;
    drive(1, 0, 0);
    repeat (3) drive(0, 0, 0);
    chk("step_e1", 32'(a_exec), 32'b10);
    drive(0, 0, 0);
    chk("step_wait", 32'(a_waits), 1);
    chk("step_retire", 32'(a_retire), 1);
    step_mode = 1'b0;
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
`ifdef STAGE_SEQ_STEP_EN
        step_mode = ($urandom_range(0, 7) == 0);
`endif
        drive($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 4) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
